pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC and target bit width.
REQ-002 Parameter RESET_VEC, default 32'h00400000, PC value on reset.
REQ-003 Parameter EXC_VEC, default 32'h00400004, exception entry address.
REQ-004 Parameter STEP, default 4, sequential PC increment.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 stall  input  1  hold PC this cycle.
REQ-008 redir_valid  input  1  branch/jump redirect request.
REQ-009 redir_target  input  WIDTH  redirect address, sampled when redir_valid=1.
REQ-010 exc_req  input  1  exception entry request.
REQ-011 eret  input  1  exception return request.
REQ-012 pc  output  WIDTH  current PC, registered.
REQ-013 epc  output  WIDTH  saved exception PC, registered.
REQ-014 pend  output  1  high while a redirect captured during stall is buffered.
REQ-015 misalign  output  1  one-cycle pulse on misaligned redirect; constant 0 when PC_ALIGN_CHECK_EN is undefined.

Function
REQ-016 Per-edge next-PC priority SHALL be: exc_req > eret > redir_valid (stall=0) > buffered redirect (stall=0) > stall hold > sequential.
REQ-017 exc_req=1 SHALL load epc<=pc and pc<=EXC_VEC, regardless of stall, and clear the buffer.
REQ-018 eret=1 with exc_req=0 SHALL load pc<=epc, regardless of stall, and clear the buffer; epc unchanged.
REQ-019 redir_valid=1 with stall=0 SHALL load pc<=redir_target and clear any buffered redirect (new target wins).
REQ-020 redir_valid=1 with stall=1 SHALL capture redir_target into the buffer, set pend, and hold pc; a later capture while pend=1 overwrites (latest wins).
REQ-021 Buffer SHALL be a two-state machine: IDLE (pend=0) and PEND (pend=1); IDLE->PEND on captured redirect; PEND->IDLE when the buffered target is applied or on exc_req/eret.
REQ-022 In PEND with stall=0, redir_valid=0, no exc_req/eret: pc<=buffered target, next state IDLE.
REQ-023 stall=1 with no exc_req/eret SHALL hold pc unchanged.
REQ-024 Otherwise pc<=pc+STEP, truncated to WIDTH bits (wraps from all-ones region to low addresses, no flag).
REQ-025 All outputs SHALL be registered; a request affects pc exactly one edge later (latency 1).

Reset
REQ-026 rst=1 SHALL asynchronously force pc=RESET_VEC, epc=0, pend=0 (IDLE), buffer=0, misalign=0.
REQ-027 rst asserted mid-operation SHALL discard any buffered redirect; first edge after deassertion with no requests yields pc=RESET_VEC+STEP.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: a redirect (direct or buffered) whose target has bit[1:0]!=0 SHALL, when it would be applied, instead load pc<=EXC_VEC, epc<=offending target, and pulse misalign for one cycle.
REQ-029 PC_ALIGN_CHECK_EN undefined: targets applied unmodified, no alignment logic, misalign tied 0.

Verification
REQ-030 Reset then 3 edges, no requests -> pc 00400000, 00400004, 00400008, 0040000C.
REQ-031 pc=00400010, stall=1 with redir_valid target 00400100, then 2 stalled cycles, stall=0 -> pend=1 during stall, pc holds 00400010, then pc=00400100, pend=0.
REQ-032 pend=1 (target 00400100), stall=0 with redir_valid target 00400200 -> pc=00400200, pend=0.
REQ-033 pc=00400020, exc_req and eret same cycle, stall=1 -> pc=00400004, epc=00400020; then eret -> pc=00400020.
REQ-034 WIDTH=32, pc=FFFFFFFC, no requests -> pc=00000000.
REQ-035 With PC_ALIGN_CHECK_EN, redirect to 00400102 -> pc=00400004, epc=00400102, misalign=1 one cycle; without macro -> pc=00400102, misalign=0.

Source files
------------

// File: rtl/pc_unit_if.sv
// Request/status bundle for pc_unit: the control side drives the requests, pc_unit drives the PC state.
interface pc_unit_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             redir_valid;
   logic [WIDTH-1:0] redir_target;
   logic             exc_req;
   logic             eret;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] epc;
   logic             pend;
   logic             misalign;

   modport master (
      output stall, redir_valid, redir_target, exc_req, eret,
      input  pc, epc, pend, misalign
   );

   modport slave (
      input  stall, redir_valid, redir_target, exc_req, eret,
      output pc, epc, pend, misalign
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with exception entry/return and a one-deep redirect buffer for stalled cycles.
// Optional misaligned-redirect trapping is enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h00400000,
   parameter logic [WIDTH-1:0] EXC_VEC   = 32'h00400004,
   parameter int unsigned      STEP      = 4
) (
   input  logic       clk,
   input  logic       rst,
   pc_unit_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } buf_state_e;

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic [WIDTH-1:0] target;
   logic             apply;
   logic             misalign_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      pc_d       = pc_q + WIDTH'(STEP);
      epc_d      = epc_q;
      buf_d      = buf_q;
      state_d    = state_q;
      target     = bus.redir_target;
      apply      = 1'b0;
      misalign_d = 1'b0;

      if (bus.exc_req) begin
         epc_d   = pc_q;
         pc_d    = EXC_VEC;
         buf_d   = '0;
         state_d = IDLE;
      end else if (bus.eret) begin
         pc_d    = epc_q;
         buf_d   = '0;
         state_d = IDLE;
      end else if (bus.redir_valid && !bus.stall) begin
         apply   = 1'b1;
         buf_d   = '0;
         state_d = IDLE;
      end else if (state_q == PEND && !bus.stall) begin
         target  = buf_q;
         apply   = 1'b1;
         buf_d   = '0;
         state_d = IDLE;
      end else if (bus.stall) begin
         pc_d = pc_q;
         if (bus.redir_valid) begin
            buf_d   = bus.redir_target;
            state_d = PEND;
         end
      end

      if (apply) begin
`ifdef PC_ALIGN_CHECK_EN
         // A misaligned target traps instead of fetching; the bad address is reported through epc.
         if (target[1:0] != 2'b00) begin
            pc_d       = EXC_VEC;
            epc_d      = target;
            misalign_d = 1'b1;
         end else begin
            pc_d = target;
         end
`else
         pc_d = target;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
      if (rst) begin
         // NOTE: the buffer is reset too, so a redirect captured before reset can never resurface.
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
         buf_q   <= '0;
         state_q <= IDLE;
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         buf_q   <= buf_d;
         state_q <= state_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end

   assign bus.misalign = misalign_q;
`else
   assign bus.misalign = 1'b0;
`endif

   assign bus.pc   = pc_q;
   assign bus.epc  = epc_q;
   assign bus.pend = (state_q == PEND);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: hand-computed vectors covering sequencing, stall buffering,
// exceptions, wrap-around, alignment trapping and mid-operation reset.
module tb_pc_unit;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   pc_unit_if #(.WIDTH(32)) bus ();

   pc_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic stall, input logic rv, input logic [31:0] tgt,
                        input logic exc, input logic er);
      bus.stall        = stall;
      bus.redir_valid  = rv;
      bus.redir_target = tgt;
      bus.exc_req      = exc;
      bus.eret         = er;
   endtask

   // Apply the given inputs across exactly one rising edge; return at the following falling edge.
   task automatic step(input logic stall, input logic rv, input logic [31:0] tgt,
                       input logic exc, input logic er);
      drive(stall, rv, tgt, exc, er);
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("reset_pc", bus.pc, 32'h00400000);
      check("reset_epc", bus.epc, 32'h0);
      check("reset_pend", {31'b0, bus.pend}, 32'h0);
      check("reset_misalign", {31'b0, bus.misalign}, 32'h0);

      @(negedge clk);
      rst = 1'b0;
      check("held_after_rst", bus.pc, 32'h00400000);

      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("seq_1", bus.pc, 32'h00400004);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("seq_2", bus.pc, 32'h00400008);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("seq_3", bus.pc, 32'h0040000C);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("seq_4", bus.pc, 32'h00400010);

      // Redirect captured during stall, held two more stalled cycles, then applied.
      step(1'b1, 1'b1, 32'h00400100, 1'b0, 1'b0);
      check("cap_pc", bus.pc, 32'h00400010);
      check("cap_pend", {31'b0, bus.pend}, 32'h1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stall1_pc", bus.pc, 32'h00400010);
      check("stall1_pend", {31'b0, bus.pend}, 32'h1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stall2_pc", bus.pc, 32'h00400010);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("buf_apply_pc", bus.pc, 32'h00400100);
      check("buf_apply_pend", {31'b0, bus.pend}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("after_apply", bus.pc, 32'h00400104);

      // A new direct redirect overrides the buffered one.
      step(1'b1, 1'b1, 32'h00400100, 1'b0, 1'b0);
      check("cap2_pend", {31'b0, bus.pend}, 32'h1);
      check("cap2_pc", bus.pc, 32'h00400104);
      step(1'b0, 1'b1, 32'h00400200, 1'b0, 1'b0);
      check("override_pc", bus.pc, 32'h00400200);
      check("override_pend", {31'b0, bus.pend}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("override_seq", bus.pc, 32'h00400204);

      // Two captures while stalled: latest target wins.
      step(1'b1, 1'b1, 32'h00400300, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h00400400, 1'b0, 1'b0);
      check("latest_hold", bus.pc, 32'h00400204);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("latest_wins", bus.pc, 32'h00400400);

      // Exception beats eret and stall; eret returns to the saved pc.
      step(1'b0, 1'b1, 32'h00400020, 1'b0, 1'b0);
      check("redir_20", bus.pc, 32'h00400020);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      check("exc_pc", bus.pc, 32'h00400004);
      check("exc_epc", bus.epc, 32'h00400020);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("eret_pc", bus.pc, 32'h00400020);
      check("eret_epc", bus.epc, 32'h00400020);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("eret_seq", bus.pc, 32'h00400024);

      // Exception discards a buffered redirect.
      step(1'b1, 1'b1, 32'h00400500, 1'b0, 1'b0);
      check("cap3_pend", {31'b0, bus.pend}, 32'h1);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check("exc_clr_pc", bus.pc, 32'h00400004);
      check("exc_clr_epc", bus.epc, 32'h00400024);
      check("exc_clr_pend", {31'b0, bus.pend}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("exc_clr_seq", bus.pc, 32'h00400008);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      check("eret_stalled", bus.pc, 32'h00400024);

      // Wrap-around at the top of the address space.
      step(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
      check("top_pc", bus.pc, 32'hFFFFFFFC);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("wrap_pc", bus.pc, 32'h00000000);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("wrap_seq", bus.pc, 32'h00000004);

      // Misaligned redirect.
      step(1'b0, 1'b1, 32'h00400102, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
      check("mis_pc", bus.pc, 32'h00400004);
      check("mis_epc", bus.epc, 32'h00400102);
      check("mis_flag", {31'b0, bus.misalign}, 32'h1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("mis_pulse_end", {31'b0, bus.misalign}, 32'h0);
      check("mis_seq", bus.pc, 32'h00400008);
`else
      check("mis_pc", bus.pc, 32'h00400102);
      check("mis_epc", bus.epc, 32'h00400024);
      check("mis_flag", {31'b0, bus.misalign}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("mis_seq", bus.pc, 32'h00400106);
`endif

      // Reset mid-operation with a buffered redirect.
      step(1'b1, 1'b1, 32'h00400600, 1'b0, 1'b0);
      check("cap4_pend", {31'b0, bus.pend}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("midrst_pc", bus.pc, 32'h00400000);
      check("midrst_epc", bus.epc, 32'h0);
      check("midrst_pend", {31'b0, bus.pend}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("postrst_pc", bus.pc, 32'h00400004);
      check("postrst_pend", {31'b0, bus.pend}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
